dma_rx_sm: RTL and testbench
============================

# dma_rx_sm

Read-side state machine of the DMA channel, paired with the write state machine `dma_tx_sm` through a single grant/handover handshake. It sequences AHB or APB read accesses from the source into the channel's holding buffer. When the buffer holds data, it hands bus ownership to the write state machine by asserting `write_grant`. It resumes reading once the write side returns to its `read_handover` state.

## Interface
- `MAX_BEATS`, default 4: maximum read beats per read phase before a forced handover (legal values 1..7).
- `hclk`  in  1  AHB clock; all state changes on its rising edge.
- `hreset`  in  1  asynchronous, active-high reset.
- `xfer_start`  in  1  one-cycle pulse that starts a programmed transfer.
- `source_apb`  in  1  source lies in APB space (1) or AHB space (0).
- `slot_available`  in  1  holding buffer can accept one more word.
- `ahb_grant`  in  1  AHB arbiter grant to the DMA master.
- `hready`  in  1  AHB ready.
- `pready`  in  1  APB bridge ready.
- `double_clk`  in  1  APB runs at half `hclk` rate.
- `count_two`  in  1  second `hclk` of a half-rate APB cycle.
- `continue_read`  in  1  datapath requests another read beat in this phase.
- `write_handover`  in  1  write state machine is in `read_handover`.
- `end_xfer`  in  1  transfer byte count exhausted.
- `abort`  in  1  channel abort.
- `write_grant`  out  1  read side has yielded; write side may proceed.
- `rd_beat`  out  1  one-cycle strobe for each completed read beat (buffer load).
- `dma_read_state`  out  5  current state.
- `next_read_state`  out  5  combinational next state.

## Operation
- States: `idle`, `read_ahb_main`, `read_ahb_addr`, `read_ahb_data`, `read_apb_main`, `read_apb_data`, `wait_for_write`, `read_xfer_finish`.
- `idle`:
  - On `xfer_start & slot_available`, go to `read_apb_main` if `source_apb`, otherwise to `read_ahb_main`.
  - If `xfer_start` arrives without `slot_available`, it is ignored.
- `read_ahb_main`: go to `read_ahb_addr` on `ahb_grant & hready`; else go to `read_xfer_finish` on `abort`.
- `read_ahb_addr`: go to `read_ahb_data` on `hready`.
- `read_ahb_data`, on `hready`:
  - Pulse `rd_beat` and increment `beat_cnt`.
  - If `continue_read & slot_available & ~(end_xfer|abort)` and `beat_cnt+1 < MAX_BEATS`, return to `read_ahb_main`.
  - Otherwise go to `wait_for_write`.
- `read_apb_main`:
  - `abort` takes priority and goes to `read_xfer_finish`.
  - Otherwise go to `read_apb_data` on `pready & (~double_clk | count_two)`.
- `read_apb_data`:
  - `abort` goes to `read_xfer_finish`.
  - Otherwise, when `~double_clk | count_two`: pulse `rd_beat`, increment `beat_cnt`, then apply the same continue rule as the AHB path, returning to `read_apb_main`.
- `wait_for_write`:
  - `write_grant = 1`, registered so it is decoded from `dma_read_state`.
  - `abort` goes to `read_xfer_finish`.
  - On `write_handover`: if `end_xfer`, go to `read_xfer_finish`; else if `slot_available`, start a new read phase (APB/AHB per `source_apb`) and clear `beat_cnt`.
  - If `write_handover` is high but there is no slot, stay in `wait_for_write`.
- `read_xfer_finish`: go to `idle` unconditionally; `beat_cnt` clears.
- `beat_cnt` is 3 bits wide, saturates at `MAX_BEATS`, and clears on entry to `idle` and on each new phase.
- Unused state codes go to `idle`.

## Timing
- Reset values: `dma_read_state = idle`, `write_grant = 0`, `rd_beat = 0`, `beat_cnt = 0`.
- Mid-operation reset forces `idle` asynchronously. Reset does not wait for `hready`.
- `write_grant` rises one cycle after the final data beat and falls the cycle after `write_handover` is sampled. The write side therefore sees `~write_grant` and moves to `wait_for_read`.
- `rd_beat` is combinational from state and inputs: it is high in the sampling cycle of each beat and never high for two consecutive cycles in APB mode.
- Minimum AHB beat: 3 cycles (main, addr, data) with `hready` tied high.
- APB beat: 2 cycles, or 4 cycles when `double_clk` is set.
- Simultaneous `abort` and `end_xfer`: abort path wins.
- `end_xfer` on the last beat leads to `wait_for_write`, so the final buffered data is still written.

## Structure
- State codes go in `dma_defs.v` as 5-bit `define`s, distinct from all write-state codes. `idle` is shared.
- `MAX_BEATS` stays local.
- There is no sub-module: one registered state process, one combinational next-state process, and a beat-count register.

## Test plan
- AHB single beat: `xfer_start`, `source_apb=0`, grant and `hready` high, `continue_read=0` → states main, addr, data, then `wait_for_write`; `rd_beat` asserted once; `write_grant=1` at cycle 4.
- AHB burst limit, `MAX_BEATS=4`: `continue_read=1` throughout → exactly 4 `rd_beat` pulses, then `wait_for_write`.
- APB with `double_clk=1` and `count_two` toggling → each beat takes 4 cycles; `rd_beat` is only asserted with `count_two=1`.
- Handover: in `wait_for_write`, `write_handover=1` with `slot_available=1` → next cycle is `read_ahb_main`, `write_grant=0`, `beat_cnt=0`.
- `abort` in `read_ahb_main` while `ahb_grant=0` → `read_xfer_finish`, then `idle`; no `rd_beat`.
- `hreset` asserted in `read_apb_data` → `idle` immediately; all outputs 0 before the next `hclk` edge.

Source files
------------

// File: rtl/dma_rx_sm_pkg.sv
// dma_rx_sm_pkg: read-side DMA state codes.
// Codes sit in 5'h10.. so they never collide with write-side codes; idle is shared.
package dma_rx_sm_pkg;

  typedef enum logic [4:0] {
    RD_IDLE     = 5'h00,
    RD_AHB_MAIN = 5'h10,
    RD_AHB_ADDR = 5'h11,
    RD_AHB_DATA = 5'h12,
    RD_APB_MAIN = 5'h13,
    RD_APB_DATA = 5'h14,
    RD_WAIT_WR  = 5'h15,
    RD_FINISH   = 5'h16
  } rd_state_t;

endpackage

// File: rtl/dma_rx_sm.sv
// dma_rx_sm: DMA channel read-side sequencer.
// Reads AHB/APB beats into the holding buffer, then yields to the write side.
import dma_rx_sm_pkg::*;

module dma_rx_sm #(
  parameter int MAX_BEATS = 4
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       xfer_start,
  input  logic       source_apb,
  input  logic       slot_available,
  input  logic       ahb_grant,
  input  logic       hready,
  input  logic       pready,
  input  logic       double_clk,
  input  logic       count_two,
  input  logic       continue_read,
  input  logic       write_handover,
  input  logic       end_xfer,
  input  logic       abort,
  output logic       write_grant,
  output logic       rd_beat,
  output logic [4:0] dma_read_state,
  output logic [4:0] next_read_state
);

  rd_state_t  state;
  rd_state_t  nxt;
  rd_state_t  phase_start;
  logic [2:0] beat_cnt;
  logic       apb_tick;
  logic       more;
  logic       new_phase;

  assign apb_tick    = ~double_clk | count_two;
  assign phase_start = source_apb ? RD_APB_MAIN : RD_AHB_MAIN;

  // room for another beat in this phase before a forced handover
  assign more = continue_read & slot_available &
                ~(end_xfer | abort) &
                (({1'b0, beat_cnt} + 4'd1) < 4'(MAX_BEATS));

  always_comb begin
    nxt       = state;
    rd_beat   = 1'b0;
    new_phase = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (xfer_start & slot_available)
          nxt = phase_start;
      end
      RD_AHB_MAIN: begin
        if (ahb_grant & hready)
          nxt = RD_AHB_ADDR;
        else if (abort)
          nxt = RD_FINISH;
      end
      RD_AHB_ADDR: begin
        if (hready)
          nxt = RD_AHB_DATA;
      end
      RD_AHB_DATA: begin
        if (hready) begin
          rd_beat = 1'b1;
          nxt     = more ? RD_AHB_MAIN : RD_WAIT_WR;
        end
      end
      RD_APB_MAIN: begin
        if (abort)
          nxt = RD_FINISH;
        else if (pready & apb_tick)
          nxt = RD_APB_DATA;
      end
      RD_APB_DATA: begin
        if (abort)
          nxt = RD_FINISH;
        else if (apb_tick) begin
          rd_beat = 1'b1;
          nxt     = more ? RD_APB_MAIN : RD_WAIT_WR;
        end
      end
      RD_WAIT_WR: begin
        if (abort)
          nxt = RD_FINISH;
        else if (write_handover) begin
          if (end_xfer)
            nxt = RD_FINISH;
          else if (slot_available) begin
            nxt       = phase_start;
            new_phase = 1'b1;
          end
        end
      end
      RD_FINISH: nxt = RD_IDLE;
      default:   nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      state <= RD_IDLE;
    else
      state <= nxt;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      beat_cnt <= 3'd0;
    else if (nxt == RD_IDLE || new_phase)
      beat_cnt <= 3'd0;
    else if (rd_beat && beat_cnt < 3'(MAX_BEATS))
      beat_cnt <= beat_cnt + 3'd1;
  end

  assign write_grant     = (state == RD_WAIT_WR);
  assign dma_read_state  = state;
  assign next_read_state = nxt;

endmodule

// File: tb/tb_dma_rx_sm.sv
// tb_dma_rx_sm: directed scenarios plus random traffic
// against a per-cycle behavioural model of the read sequencer.
module tb_dma_rx_sm;
  import dma_rx_sm_pkg::*;

  localparam int MAXB = 4;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       xfer_start, source_apb, slot_available;
  logic       ahb_grant, hready, pready, double_clk;
  logic       count_two, continue_read, write_handover;
  logic       end_xfer, abort;
  logic       write_grant, rd_beat;
  logic [4:0] dma_read_state, next_read_state;

  dma_rx_sm #(.MAX_BEATS(MAXB)) dut (
    .hclk           (hclk),
    .hreset         (hreset),
    .xfer_start     (xfer_start),
    .source_apb     (source_apb),
    .slot_available (slot_available),
    .ahb_grant      (ahb_grant),
    .hready         (hready),
    .pready         (pready),
    .double_clk     (double_clk),
    .count_two      (count_two),
    .continue_read  (continue_read),
    .write_handover (write_handover),
    .end_xfer       (end_xfer),
    .abort          (abort),
    .write_grant    (write_grant),
    .rd_beat        (rd_beat),
    .dma_read_state (dma_read_state),
    .next_read_state(next_read_state)
  );

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model phases, deliberately numbered independently of the DUT codes
  localparam int M_IDLE = 0, M_AM = 1, M_AA = 2, M_AD = 3;
  localparam int M_PM = 4, M_PD = 5, M_WAIT = 6, M_FIN = 7;

  int m_st, m_nx, m_beats, m_tot;
  bit m_rd;
  int rd_cnt, bad_ct2, dut_tot;

  function automatic logic [4:0] code(input int s);
    case (s)
      M_AM:    return RD_AHB_MAIN;
      M_AA:    return RD_AHB_ADDR;
      M_AD:    return RD_AHB_DATA;
      M_PM:    return RD_APB_MAIN;
      M_PD:    return RD_APB_DATA;
      M_WAIT:  return RD_WAIT_WR;
      M_FIN:   return RD_FINISH;
      default: return RD_IDLE;
    endcase
  endfunction

  task automatic model_eval();
    bit tick, go_on;
    int start;
    tick  = !double_clk || count_two;
    go_on = continue_read && slot_available && !end_xfer && !abort
            && (m_beats + 1 < MAXB);
    start = source_apb ? M_PM : M_AM;
    m_rd  = 0;
    m_nx  = m_st;
    case (m_st)
      M_IDLE: if (xfer_start && slot_available) m_nx = start;
      M_AM: begin
        if (ahb_grant && hready) m_nx = M_AA;
        else if (abort) m_nx = M_FIN;
      end
      M_AA: if (hready) m_nx = M_AD;
      M_AD: if (hready) begin
        m_rd = 1;
        m_nx = go_on ? M_AM : M_WAIT;
      end
      M_PM: begin
        if (abort) m_nx = M_FIN;
        else if (pready && tick) m_nx = M_PD;
      end
      M_PD: begin
        if (abort) m_nx = M_FIN;
        else if (tick) begin
          m_rd = 1;
          m_nx = go_on ? M_PM : M_WAIT;
        end
      end
      M_WAIT: begin
        if (abort) m_nx = M_FIN;
        else if (write_handover && end_xfer) m_nx = M_FIN;
        else if (write_handover && slot_available) m_nx = start;
      end
      default: m_nx = M_IDLE;
    endcase
  endtask

  // one clock: check at posedge+2, advance model at the edge
  task automatic cyc();
    #1;
    model_eval();
    chk("state", dma_read_state, code(m_st));
    chk("next", next_read_state, code(m_nx));
    chk("grant", write_grant, (m_st == M_WAIT));
    chk("rd_beat", rd_beat, m_rd);
    if (rd_beat === 1'b1) begin
      rd_cnt++;
      dut_tot++;
      if (double_clk && !count_two) bad_ct2++;
    end
    @(posedge hclk);
    if (m_rd) begin
      m_tot++;
      if (m_beats < MAXB) m_beats++;
    end
    if (m_nx == M_IDLE || (m_st == M_WAIT && m_nx != M_WAIT))
      m_beats = 0;
    m_st = m_nx;
    #1;
  endtask

  task automatic idle_inputs();
    xfer_start     = 0; source_apb    = 0; slot_available = 1;
    ahb_grant      = 1; hready        = 1; pready         = 1;
    double_clk     = 0; count_two     = 0; continue_read  = 0;
    write_handover = 0; end_xfer      = 0; abort          = 0;
  endtask

  initial begin
    idle_inputs();
    hreset = 1;
    m_st = M_IDLE; m_beats = 0; m_tot = 0;
    rd_cnt = 0; bad_ct2 = 0; dut_tot = 0;
    #12;
    chk("rst_state", dma_read_state, RD_IDLE);
    chk("rst_grant", write_grant, 0);
    chk("rst_rd", rd_beat, 0);
    @(posedge hclk); #1;
    hreset = 0;

    // AHB single beat
    xfer_start = 1; rd_cnt = 0;
    cyc();
    xfer_start = 0;
    repeat (3) cyc();
    chk("ahb1_state", dma_read_state, RD_WAIT_WR);
    chk("ahb1_grant", write_grant, 1);
    chk("ahb1_beats", rd_cnt, 1);

    // handover with a free slot restarts reading
    write_handover = 1;
    cyc();
    write_handover = 0;
    chk("ho_state", dma_read_state, RD_AHB_MAIN);
    chk("ho_grant", write_grant, 0);

    // abort while the AHB bus is not granted
    ahb_grant = 0; abort = 1; rd_cnt = 0;
    cyc();
    abort = 0;
    chk("abort_fin", dma_read_state, RD_FINISH);
    cyc();
    chk("abort_idle", dma_read_state, RD_IDLE);
    chk("abort_beats", rd_cnt, 0);

    // AHB burst capped by MAX_BEATS
    ahb_grant = 1; continue_read = 1; xfer_start = 1; rd_cnt = 0;
    cyc();
    xfer_start = 0;
    repeat (12) cyc();
    chk("burst_beats", rd_cnt, MAXB);
    chk("burst_state", dma_read_state, RD_WAIT_WR);
    write_handover = 1; end_xfer = 1;
    cyc();
    chk("end_fin", dma_read_state, RD_FINISH);
    write_handover = 0; end_xfer = 0;
    cyc();

    // APB half-rate: 4 cycles per beat
    source_apb = 1; double_clk = 1; count_two = 1; xfer_start = 1;
    cyc();
    xfer_start = 0; rd_cnt = 0; bad_ct2 = 0;
    repeat (16) begin
      count_two = ~count_two;
      cyc();
    end
    chk("apb_beats", rd_cnt, MAXB);
    chk("apb_ct2", bad_ct2, 0);
    chk("apb_state", dma_read_state, RD_WAIT_WR);
    abort = 1;
    cyc();
    abort = 0;
    cyc();

    // asynchronous reset in read_apb_data
    continue_read = 0; xfer_start = 1; count_two = 1;
    cyc();
    xfer_start = 0;
    cyc();
    count_two = 0;
    cyc();
    chk("pre_rst", dma_read_state, RD_APB_DATA);
    hreset = 1;
    #1;
    chk("arst_state", dma_read_state, RD_IDLE);
    chk("arst_next", next_read_state, RD_IDLE);
    chk("arst_grant", write_grant, 0);
    chk("arst_rd", rd_beat, 0);
    m_st = M_IDLE; m_beats = 0;
    @(posedge hclk); #1;
    hreset = 0;

    // random traffic
    idle_inputs();
    repeat (1500) begin
      xfer_start     = ($urandom % 6) == 0;
      source_apb     = $urandom % 2;
      slot_available = ($urandom % 5) != 0;
      ahb_grant      = ($urandom % 4) != 0;
      hready         = ($urandom % 5) != 0;
      pready         = ($urandom % 3) != 0;
      double_clk     = $urandom % 2;
      count_two      = $urandom % 2;
      continue_read  = ($urandom % 4) != 0;
      write_handover = ($urandom % 3) == 0;
      end_xfer       = ($urandom % 8) == 0;
      abort          = ($urandom % 20) == 0;
      cyc();
    end
    chk("total_beats", dut_tot, m_tot);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
